// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: captures PC/instruction, stalls on ifid_write=0, inserts FLUSH_CYCLES bubbles on flush.
// Optional stall/flush performance counters are built when IFID_PERF_CNT_EN is defined.
module if_id_stage_reg #(
  parameter int                   PC_W         = 7,
  parameter int                   INSTR_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR    = INSTR_W'(32'h0000_0000),
  parameter int                   FLUSH_CYCLES = 1,
  parameter int                   CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               ifid_write,
  input  logic               flush,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus4_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic               bubble_active
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [2:0]      RELOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_FOUR = PC_W'(4);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      // A flush discards the fetch but leaves the PC pair pointing at the last real instruction
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      cnt_d   = RELOAD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      cnt_d   = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = RUN;
    end else if (ifid_write) begin
      pc_d    = pc_in;
      pc4_d   = pc_in + PC_FOUR;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= PC_FOUR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_plus4_out  = pc4_q;
  assign instr_out     = instr_q;
  assign valid_out     = valid_q;
  assign bubble_active = (state_q == FLUSH);

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == RUN && !flush && !ifid_write && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: one instance with FLUSH_CYCLES=1, one with FLUSH_CYCLES=3 and 3-bit counters.
module tb_if_id_stage_reg;

  logic        clk, reset, ifid_write, flush;
  logic [6:0]  pc_in;
  logic [31:0] instr_in;

  logic [6:0]  pc1, pc41, pc3, pc43;
  logic [31:0] ins1, ins3;
  logic        v1, v3, b1, b3;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] sc1, fc1;
  logic [2:0]  sc3, fc3;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  pc;
    logic [6:0]  pc4;
    logic [31:0] instr;
    logic        valid;
    logic        bubble;
    logic [15:0] stall;
    logic [15:0] fl;
  } obs_t;

  typedef struct {
    int unsigned pc, pc4, stall, fl, cnt;
    logic [31:0] instr;
    bit          valid, fs;
  } mdl_t;

  mdl_t m1, m3;
  obs_t q1[$], q3[$];

  if_id_stage_reg #(.FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .ifid_write(ifid_write), .flush(flush), .pc_out(pc1), .pc_plus4_out(pc41),
    .instr_out(ins1), .valid_out(v1), .bubble_active(b1)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  if_id_stage_reg #(.FLUSH_CYCLES(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .ifid_write(ifid_write), .flush(flush), .pc_out(pc3), .pc_plus4_out(pc43),
    .instr_out(ins3), .valid_out(v3), .bubble_active(b3)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pc = 0; m.pc4 = 4; m.instr = 32'h0; m.valid = 0; m.fs = 0;
    m.cnt = 0; m.stall = 0; m.fl = 0;
    return m;
  endfunction

  // Reference behaviour of one clock edge.
  function automatic mdl_t nxt(mdl_t m, int fcyc, int cw, bit fl, bit wr,
                               logic [6:0] pc, logic [31:0] ins);
    mdl_t n = m;
    int unsigned mx = (1 << cw) - 1;
    if (!m.fs && !fl && !wr && m.stall < mx) n.stall = m.stall + 1;
    if (fl && m.fl < mx) n.fl = m.fl + 1;
    if (fl) begin
      n.instr = 32'h0; n.valid = 0; n.cnt = fcyc - 1; n.fs = (fcyc > 1);
    end else if (m.fs) begin
      n.instr = 32'h0; n.valid = 0; n.cnt = m.cnt - 1;
      if (m.cnt == 1) n.fs = 0;
    end else if (wr) begin
      n.pc = pc; n.pc4 = (pc + 4) % 128; n.instr = ins; n.valid = 1;
    end
    return n;
  endfunction

  function automatic obs_t to_obs(mdl_t m);
    obs_t o;
    o.pc = 7'(m.pc); o.pc4 = 7'(m.pc4); o.instr = m.instr;
    o.valid = m.valid; o.bubble = m.fs;
`ifdef IFID_PERF_CNT_EN
    o.stall = 16'(m.stall); o.fl = 16'(m.fl);
`else
    o.stall = '0; o.fl = '0;
`endif
    return o;
  endfunction

  function automatic obs_t samp1();
    obs_t o;
    o.pc = pc1; o.pc4 = pc41; o.instr = ins1; o.valid = v1; o.bubble = b1;
`ifdef IFID_PERF_CNT_EN
    o.stall = sc1; o.fl = fc1;
`else
    o.stall = '0; o.fl = '0;
`endif
    return o;
  endfunction

  function automatic obs_t samp3();
    obs_t o;
    o.pc = pc3; o.pc4 = pc43; o.instr = ins3; o.valid = v3; o.bubble = b3;
`ifdef IFID_PERF_CNT_EN
    o.stall = {13'd0, sc3}; o.fl = {13'd0, fc3};
`else
    o.stall = '0; o.fl = '0;
`endif
    return o;
  endfunction

  // Drive one cycle, push expectations, sample 1 time unit after the edge.
  task automatic step(input bit fl, input bit wr, input logic [6:0] pc, input logic [31:0] ins);
    flush = fl; ifid_write = wr; pc_in = pc; instr_in = ins;
    m1 = nxt(m1, 1, 16, fl, wr, pc, ins);
    m3 = nxt(m3, 3, 3, fl, wr, pc, ins);
    q1.push_back(to_obs(m1));
    q3.push_back(to_obs(m3));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    reset = 1'b1; flush = 0; ifid_write = 0; pc_in = 0; instr_in = 0;
    m1 = mdl_reset(); m3 = mdl_reset();
    #12;
    e = to_obs(m1); a = samp1(); checks++;
    if (a !== e) begin errors++; $display("FAIL reset_dut1 got %h exp %h", a, e); end
    e = to_obs(m3); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL reset_dut3 got %h exp %h", a, e); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    obs_t e, a;
    step(0, 1, 7'd8, 32'h00A30333);
    e = q1.pop_front(); a = samp1(); checks++;
    if (a !== e) begin errors++; $display("FAIL load_dut1 got %h exp %h", a, e); end
    e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL load_dut3 got %h exp %h", a, e); end
  endtask

  task automatic test_stall();
    obs_t e, a;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 7'd12, 32'hDEADBEEF);
      e = q1.pop_front(); a = samp1(); checks++;
      if (a !== e) begin errors++; $display("FAIL stall%0d_dut1 got %h exp %h", i, a, e); end
      e = q3.pop_front(); a = samp3(); checks++;
      if (a !== e) begin errors++; $display("FAIL stall%0d_dut3 got %h exp %h", i, a, e); end
    end
  endtask

  task automatic test_flush_over_stall();
    obs_t e, a;
    step(1, 0, 7'd12, 32'hDEADBEEF);
    e = q1.pop_front(); a = samp1(); checks++;
    if (a !== e) begin errors++; $display("FAIL flush_stall_dut1 got %h exp %h", a, e); end
    e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL flush_stall_dut3 got %h exp %h", a, e); end
    // Let the 3-cycle instance drain back to RUN.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 7'd12, 32'hDEADBEEF);
      e = q1.pop_front(); a = samp1(); checks++;
      if (a !== e) begin errors++; $display("FAIL drain%0d_dut1 got %h exp %h", i, a, e); end
      e = q3.pop_front(); a = samp3(); checks++;
      if (a !== e) begin errors++; $display("FAIL drain%0d_dut3 got %h exp %h", i, a, e); end
    end
  endtask

  task automatic test_extended_flush();
    obs_t e, a;
    step(0, 1, 7'd16, 32'h11111111);
    void'(q1.pop_front()); e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL xflush_pre got %h exp %h", a, e); end
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 1, 7'd20, 32'h22222222);
      e = q1.pop_front(); a = samp1(); checks++;
      if (a !== e) begin errors++; $display("FAIL xflush%0d_dut1 got %h exp %h", i, a, e); end
      e = q3.pop_front(); a = samp3(); checks++;
      if (a !== e) begin errors++; $display("FAIL xflush%0d_dut3 got %h exp %h", i, a, e); end
      checks++;
      if (v3 !== (i >= 3) || b3 !== (i < 2)) begin
        errors++; $display("FAIL xflush_seq%0d valid %b bubble %b", i, v3, b3);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    step(0, 1, 7'd124, 32'h0040_0093);
    e = q1.pop_front(); a = samp1(); checks++;
    if (a !== e) begin errors++; $display("FAIL wrap_dut1 got %h exp %h", a, e); end
    e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL wrap_dut3 got %h exp %h", a, e); end
  endtask

  task automatic test_async_reset();
    obs_t e, a;
    step(1, 1, 7'd40, 32'h33333333);
    void'(q1.pop_front()); e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL areset_pre got %h exp %h", a, e); end
    #2 reset = 1'b1;
    #1;
    m1 = mdl_reset(); m3 = mdl_reset();
    e = to_obs(m1); a = samp1(); checks++;
    if (a !== e) begin errors++; $display("FAIL areset_dut1 got %h exp %h", a, e); end
    e = to_obs(m3); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL areset_dut3 got %h exp %h", a, e); end
    #2 reset = 1'b0;
    step(0, 1, 7'd44, 32'h44444444);
    void'(q1.pop_front()); e = q3.pop_front(); a = samp3(); checks++;
    if (a !== e) begin errors++; $display("FAIL areset_post got %h exp %h", a, e); end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
           7'($urandom), $urandom);
      e = q1.pop_front(); a = samp1(); checks++;
      if (a !== e) begin errors++; $display("FAIL rand%0d_dut1 got %h exp %h", i, a, e); end
      e = q3.pop_front(); a = samp3(); checks++;
      if (a !== e) begin errors++; $display("FAIL rand%0d_dut3 got %h exp %h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_extended_flush();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
